// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the peripheral bus bridge.
`timescale 1ns/1ps
package periph_bus_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_DONE} eng_state_t;

  localparam int unsigned REGION_BIT = 13;
  localparam logic [31:0] ERR_RDATA  = 32'h0;
endpackage

// File: rtl/periph_wbuf.sv
// Posted-write buffer: 2^BUF_POW entries, wrap-bit pointers for full/empty.
`timescale 1ns/1ps
module periph_wbuf #(
  parameter int BUF_POW = 4,
  parameter int W       = 45
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int DEPTH = 2 ** BUF_POW;

  logic [BUF_POW:0] wr_ptr_q, rd_ptr_q;
  logic [W-1:0]     mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[BUF_POW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q[BUF_POW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[BUF_POW] != rd_ptr_q[BUF_POW]) &&
                   (wr_ptr_q[BUF_POW-1:0] == rd_ptr_q[BUF_POW-1:0]);
endmodule

// File: rtl/periph_bus.sv
// Core data port split into a single-cycle memory path and a peripheral
// space with posted writes, ordered reads and a ready timeout.
`timescale 1ns/1ps
module periph_bus
  import periph_bus_pkg::*;
#(
  parameter int N_SLV   = 6,
  parameter int BUF_POW = 4,
  parameter int REG_W   = 6,
  parameter int TMO     = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               data_req_i,
  input  logic               data_we_i,
  input  logic [3:0]         data_be_i,
  input  logic [13:0]        data_addr_i,
  input  logic [31:0]        data_wdata_i,
  output logic               data_gnt_o,
  output logic               data_rvalid_o,
  output logic [31:0]        data_rdata_o,
  output logic               data_err_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [3:0]         mem_be_o,
  output logic [12:0]        mem_addr_o,
  output logic [31:0]        mem_wdata_o,
  input  logic [31:0]        mem_rdata_i,
  output logic [N_SLV-1:0]   per_sel_o,
  output logic               per_we_o,
  output logic [3:0]         per_be_o,
  output logic [REG_W-1:0]   per_addr_o,
  output logic [31:0]        per_wdata_o,
  input  logic [32*N_SLV-1:0] per_rdata_i,
  input  logic [N_SLV-1:0]   per_ready_i
);
  localparam int EW = 4 + REG_W + 32 + 3;
  localparam int TW = $clog2(TMO + 1);

  eng_state_t state_q, state_d;
  logic [TW-1:0] tmo_cnt_q;
  logic          rd_pend_q;
  logic [2:0]    rd_slot_q;
  logic [REG_W-1:0] rd_reg_q;
  logic [3:0]    rd_be_q;
  logic [31:0]   rd_data_q;
  logic          rd_err_q;
  logic          rsp_v_q, rsp_mem_q, rsp_err_q;

  logic          is_per, slot_ok, gnt, mem_req, push, pop, rd_start;
  logic [2:0]    slot, cur_slot;
  logic          fifo_empty, fifo_full, hit, tmo_hit, active;
  logic [EW-1:0] head;
  logic [N_SLV-1:0] sel_v;
  logic [31:0]   per_rd;

  assign is_per  = data_addr_i[REGION_BIT];
  assign slot    = data_addr_i[REG_W+2:REG_W];
  assign slot_ok = int'(slot) < N_SLV;

  // Reads to valid slots wait for the write buffer to drain so they observe prior writes.
  always_comb begin
    gnt = 1'b0;
    if (!rst_i && data_req_i && !rd_pend_q) begin
      if (!is_per)        gnt = 1'b1;
      else if (!slot_ok)  gnt = 1'b1;
      else if (data_we_i) gnt = !fifo_full;
      else                gnt = fifo_empty && (state_q == ST_IDLE);
    end
  end

  assign mem_req  = gnt && !is_per;
  assign push     = gnt && is_per && slot_ok && data_we_i;
  assign rd_start = gnt && is_per && slot_ok && !data_we_i;

  periph_wbuf #(.BUF_POW(BUF_POW), .W(EW)) u_wbuf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   ({data_be_i, data_addr_i[REG_W-1:0], data_wdata_i, slot}),
    .pop_i   (pop),
    .dout_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign cur_slot = (state_q == ST_WR) ? head[2:0] : rd_slot_q;
  assign active   = (state_q == ST_WR) || (state_q == ST_RD);

  always_comb begin
    sel_v  = '0;
    per_rd = '0;
    for (int unsigned k = 0; k < N_SLV; k++) begin
      if (cur_slot == 3'(k)) begin
        sel_v[k] = 1'b1;
        per_rd   = per_rdata_i[32*k +: 32];
      end
    end
  end

  assign hit     = |(per_ready_i & sel_v);
  assign tmo_hit = (tmo_cnt_q == TW'(TMO));

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty)   state_d = ST_WR;
        else if (rd_start) state_d = ST_RD;
      end
      ST_WR: begin
        if (hit || tmo_hit) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RD:   if (hit || tmo_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      rd_slot_q <= '0;
      rd_reg_q  <= '0;
      rd_be_q   <= '0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
      rsp_v_q   <= 1'b0;
      rsp_mem_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= (state_d != state_q || !active) ? '0 : tmo_cnt_q + TW'(1);
      if (rd_start) begin
        rd_pend_q <= 1'b1;
        rd_slot_q <= slot;
        rd_reg_q  <= data_addr_i[REG_W-1:0];
        rd_be_q   <= data_be_i;
      end else if (state_q == ST_DONE) begin
        rd_pend_q <= 1'b0;
      end
      if (state_q == ST_RD) begin
        if (hit) begin
          rd_data_q <= per_rd;
          rd_err_q  <= 1'b0;
        end else if (tmo_hit) begin
          rd_data_q <= ERR_RDATA;
          rd_err_q  <= 1'b1;
        end
      end
      rsp_v_q   <= gnt && !rd_start;
      rsp_mem_q <= mem_req && !data_we_i;
      rsp_err_q <= gnt && is_per && !slot_ok;
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rsp_v_q || (state_q == ST_DONE);
  assign data_err_o    = (state_q == ST_DONE) ? rd_err_q : (rsp_v_q && rsp_err_q);
  assign data_rdata_o  = (state_q == ST_DONE)  ? rd_data_q :
                         (rsp_v_q && rsp_mem_q) ? mem_rdata_i : '0;

  assign mem_req_o   = mem_req;
  assign mem_we_o    = mem_req && data_we_i;
  assign mem_be_o    = mem_req ? data_be_i : '0;
  assign mem_addr_o  = mem_req ? data_addr_i[12:0] : '0;
  assign mem_wdata_o = mem_req ? data_wdata_i : '0;

  assign per_sel_o   = active ? sel_v : '0;
  assign per_we_o    = (state_q == ST_WR);
  assign per_be_o    = (state_q == ST_WR) ? head[EW-1 -: 4] :
                       (state_q == ST_RD) ? rd_be_q : '0;
  assign per_addr_o  = (state_q == ST_WR) ? head[34+REG_W:35] :
                       (state_q == ST_RD) ? rd_reg_q : '0;
  assign per_wdata_o = (state_q == ST_WR) ? head[34:3] : '0;
endmodule

// File: tb/tb_periph_bus.sv
// Directed bench for periph_bus: single-cycle vectors plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_periph_bus;
  localparam int N_SLV = 6;
  localparam int BUF_POW = 4;
  localparam int REG_W = 6;
  localparam int TMO = 255;

  logic clk = 1'b0;
  logic rst;
  logic req, we;
  logic [3:0] be;
  logic [13:0] addr;
  logic [31:0] wdata;
  logic gnt, rvalid, err;
  logic [31:0] rdata;
  logic mem_req, mem_we;
  logic [3:0] mem_be;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [N_SLV-1:0] per_sel;
  logic per_we;
  logic [3:0] per_be;
  logic [REG_W-1:0] per_addr;
  logic [31:0] per_wdata;
  logic [32*N_SLV-1:0] per_rdata;
  logic [N_SLV-1:0] per_ready;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  periph_bus #(.N_SLV(N_SLV), .BUF_POW(BUF_POW), .REG_W(REG_W), .TMO(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(req), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
    .data_wdata_i(wdata), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
    .data_rdata_o(rdata), .data_err_o(err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .per_sel_o(per_sel), .per_we_o(per_we), .per_be_o(per_be),
    .per_addr_o(per_addr), .per_wdata_o(per_wdata),
    .per_rdata_i(per_rdata), .per_ready_i(per_ready)
  );

  typedef struct {
    logic        req;
    logic        we;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic        e_gnt;
    logic        e_mreq;
    logic [12:0] e_maddr;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [13:0] a, input logic [31:0] d);
    req = r; we = w; be = 4'hF; addr = a; wdata = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int n;
    rst = 1'b1; per_ready = '0; mem_rdata = '0;
    for (int k = 0; k < N_SLV; k++) per_rdata[32*k +: 32] = 32'h0B0B_0000 + 32'(k);
    per_rdata[63:32] = 32'h1234_5678;
    drive(1'b1, 1'b0, 14'h0010, 32'h0);

    vecs[0] = '{1'b1, 1'b0, 14'h0010, 32'h0,      32'hDEAD_BEEF, 1'b1, 1'b1, 13'h0010, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 14'h1FFF, 32'h55AA,   32'h1111_1111, 1'b1, 1'b1, 13'h1FFF, 32'h0,          1'b0};
    vecs[2] = '{1'b1, 1'b0, 14'h21C0, 32'h0,      32'h2222_2222, 1'b1, 1'b0, 13'h0,    32'h0,          1'b1};
    vecs[3] = '{1'b1, 1'b1, 14'h2180, 32'h77,     32'h3333_3333, 1'b1, 1'b0, 13'h0,    32'h0,          1'b1};
    vecs[4] = '{1'b0, 1'b0, 14'h0020, 32'h0,      32'h4444_4444, 1'b0, 1'b0, 13'h0,    32'h0,          1'b0};
    vecs[5] = '{1'b1, 1'b0, 14'h1234, 32'h0,      32'hCAFE_F00D, 1'b1, 1'b1, 13'h1234, 32'hCAFE_F00D, 1'b0};

    // reset state, with a live request that must be ignored
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_per_sel", 32'(per_sel), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      mem_rdata = vecs[i].mrd;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
      chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].e_mreq));
      chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_maddr));
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].e_gnt));
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e_err));
      chk($sformatf("v%0d_per_sel", i), 32'(per_sel), 32'd0);
    end

    // fill the write buffer to slot 2 with no ready
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 14'h2080 | 14'(i), 32'h1000 + 32'(i));
      @(negedge clk);
      chk($sformatf("fill%0d_gnt", i), 32'(gnt), 32'd1);
      if (i > 0) chk($sformatf("fill%0d_rsp", i), {30'd0, rvalid, err}, 32'd2);
    end
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 14'h2090, 32'h1010);
    @(negedge clk);
    chk("full_gnt0", 32'(gnt), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("full_gnt1", 32'(gnt), 32'd0);
    chk("wr_per_sel", 32'(per_sel), 32'h04);
    chk("wr_per_we", 32'(per_we), 32'd1);
    chk("wr_per_wdata", per_wdata, 32'h1000);
    chk("wr_per_addr", 32'(per_addr), 32'd0);
    @(posedge clk); #1;
    per_ready = 6'b000100;
    @(negedge clk);
    chk("full_pop_gnt", 32'(gnt), 32'd0);
    @(posedge clk); #1;
    per_ready = '0;
    @(negedge clk);
    chk("after_pop_gnt", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    per_ready = '1;
    got = 0;
    for (int c = 0; c < 200 && got < 16; c++) begin
      @(negedge clk);
      if (per_sel != '0 && per_we) begin
        chk($sformatf("drain%0d_wdata", got), per_wdata, 32'h1001 + 32'(got));
        got++;
      end
      @(posedge clk);
    end
    chk("drain_count", 32'(got), 32'd16);
    #1 per_ready = '0;

    // write then read slot 1: read held behind the buffered write
    @(posedge clk); @(posedge clk); #1;
    drive(1'b1, 1'b1, 14'h2043, 32'hA5A5_A5A5);
    @(negedge clk);
    chk("ord_wr_gnt", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 14'h2045, 32'h0);
    @(negedge clk);
    chk("ord_rd_held0", 32'(gnt), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("ord_rd_held1", 32'(gnt), 32'd0);
    chk("ord_wr_sel", 32'(per_sel), 32'h02);
    chk("ord_wr_wdata", per_wdata, 32'hA5A5_A5A5);
    chk("ord_wr_addr", 32'(per_addr), 32'd3);
    @(posedge clk); #1;
    per_ready = 6'b000010;
    @(negedge clk);
    chk("ord_rd_held2", 32'(gnt), 32'd0);
    @(posedge clk); #1;
    per_ready = '0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (gnt) break;
      @(posedge clk); #1;
      n++;
    end
    chk("ord_rd_gnt_wait", 32'(n), 32'd0);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("ord_rd_sel", 32'(per_sel), 32'h02);
    chk("ord_rd_we", 32'(per_we), 32'd0);
    chk("ord_rd_addr", 32'(per_addr), 32'd5);
    @(posedge clk); #1;
    per_ready = 6'b000010;
    @(negedge clk);
    chk("ord_rd_no_early_rvalid", 32'(rvalid), 32'd0);
    @(posedge clk); #1;
    per_ready = '0;
    @(negedge clk);
    chk("ord_rvalid", 32'(rvalid), 32'd1);
    chk("ord_rdata", rdata, 32'h1234_5678);
    chk("ord_err", 32'(err), 32'd0);
    chk("ord_done_sel", 32'(per_sel), 32'd0);

    // read slot 0 with no ready: timeout
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 14'h2000, 32'h0);
    @(negedge clk);
    chk("tmo_gnt", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    n = 1;
    while (n <= TMO + 5) begin
      @(negedge clk);
      if (n == 1) chk("tmo_rd_sel", 32'(per_sel), 32'h01);
      if (rvalid) break;
      @(posedge clk);
      n++;
    end
    chk("tmo_latency", 32'(n), 32'(TMO + 2));
    chk("tmo_rdata", rdata, 32'd0);
    chk("tmo_err", 32'(err), 32'd1);

    // reset with three writes buffered
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 14'h20C0 | 14'(i), 32'h3000 + 32'(i));
      @(negedge clk);
      chk($sformatf("rb%0d_gnt", i), 32'(gnt), 32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b1, 1'b0, 14'h0100, 32'h0);
    @(negedge clk);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
    chk("mid_rst_per_sel", 32'(per_sel), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_idle", i), {25'd0, per_sel, rvalid}, 32'd0);
      @(posedge clk);
    end
    #1 drive(1'b1, 1'b0, 14'h20C2, 32'h0);
    @(negedge clk);
    chk("post_rst_rd_gnt", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    req = 1'b0; per_ready = 6'b001000;
    @(negedge clk);
    chk("post_rst_rd_sel", 32'(per_sel), 32'h08);
    @(posedge clk); #1;
    per_ready = '0;
    @(negedge clk);
    chk("post_rst_rdata", rdata, 32'h0B0B_0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/periph_bus.md
PERIPH_BUS -- requirements
Module: periph_bus

Interface
REQ-001 SHALL have parameter N_SLV, default 6, number of peripheral slots (1..8).
REQ-002 SHALL have parameter BUF_POW, default 4, posted-write buffer depth = 2^BUF_POW.
REQ-003 SHALL have parameter REG_W, default 6, peripheral register address bits.
REQ-004 SHALL have parameter TMO, default 255, peripheral ready timeout in cycles.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
REQ-006 clk_i  in  1  clock, all state on rising edge.
REQ-007 rst_i  in  1  asynchronous active-high reset.
REQ-008 data_req_i, data_we_i  in  1 each  core request, write enable.
REQ-009 data_be_i  in  4  byte enables; data_addr_i  in  14  word address; data_wdata_i  in  32.
REQ-010 data_gnt_o  out  1  request accepted this cycle.
REQ-011 data_rvalid_o  out  1  response pulse; data_rdata_o  out  32; data_err_o  out  1, qualified by rvalid.
REQ-012 mem_req_o, mem_we_o  out  1; mem_be_o  out  4; mem_addr_o  out  13; mem_wdata_o  out  32; mem_rdata_i  in  32, valid the cycle after mem_req_o.
REQ-013 per_sel_o  out  N_SLV  one-hot; per_we_o  out  1; per_be_o  out  4; per_addr_o  out  REG_W; per_wdata_o  out  32.
REQ-014 per_rdata_i  in  32*N_SLV, slot k at [32k+31:32k]; per_ready_i  in  N_SLV, completes the selected access.

Function
REQ-015 addr[13]=0 SHALL route to memory; addr[13]=1 to peripheral space, slot = addr[REG_W+2:REG_W], register = addr[REG_W-1:0].
REQ-016 At most one non-posted transaction SHALL be outstanding; data_gnt_o=0 while a read is pending response.
REQ-017 Memory access: gnt same cycle as req, mem_req_o combinational, rvalid exactly 1 cycle later, rdata=mem_rdata_i for reads.
REQ-018 Peripheral write: pushed to FIFO, gnt same cycle, rvalid 1 cycle later (posted), err=0.
REQ-019 Peripheral write SHALL NOT be granted while FIFO count (registered) = 2^BUF_POW, even if a pop occurs that cycle.
REQ-020 Engine FSM states IDLE, WR, RD, DONE.
REQ-021 IDLE->WR when FIFO non-empty; WR drives head entry on per_* until selected per_ready_i=1, then pops; WR->IDLE.
REQ-022 Peripheral read SHALL be held until FIFO empty and FSM IDLE (ordering), then IDLE->RD; RD until per_ready_i, capture per_rdata_i, RD->DONE; DONE issues rvalid, ->IDLE.
REQ-023 Slot index >= N_SLV: write dropped (not buffered), rvalid next cycle with err=1; read returns rdata=0, err=1, rvalid next cycle, no per_sel.
REQ-024 Timeout counter SHALL count cycles in WR or RD; on reaching TMO abort access, pop entry (WR) or return rdata=0 err=1 (RD); counter clears on every state entry.
REQ-025 FIFO pointers BUF_POW+1 bits, wrap modulo 2^(BUF_POW+1); full/empty from MSB compare.
REQ-026 Simultaneous FIFO push and pop SHALL leave count unchanged and both entries correct.
REQ-027 per_sel_o SHALL be zero outside WR/RD.

Reset
REQ-028 Reset SHALL clear FSM to IDLE, FIFO pointers and count to 0, timeout counter to 0, pending-read flag to 0.
REQ-029 During reset all outputs SHALL be 0, data_rdata_o=0; reset mid-access discards buffered writes and any pending response.

Structure
REQ-030 Package periph_bus_pkg SHALL hold FSM state typedef, region bit index (13), ERR_RDATA (32'h0).
REQ-031 FIFO SHALL be a sub-module periph_wbuf (params BUF_POW, width 4+REG_W+32+3).

Verification
REQ-032 Memory read addr 0x0010 -> mem_req_o same cycle, rvalid next cycle, rdata=mem_rdata_i.
REQ-033 17 back-to-back writes to slot 2, per_ready_i=0 -> 16 granted, 17th gnt=0 until first ready pulse.
REQ-034 Write slot 1 then read slot 1 reg 5 -> read issued only after write completes; rdata=per_rdata_i slot 1, err=0.
REQ-035 Read slot 7 (N_SLV=6) -> rvalid next cycle, rdata=0, err=1, per_sel_o stays 0.
REQ-036 Read slot 0, per_ready_i held 0 -> rvalid exactly TMO cycles after RD entry +1, err=1.
REQ-037 Assert rst_i with 3 entries buffered -> FIFO empty, per_sel_o=0, no rvalid after release.
